// File: rtl/fetch_unit.sv
// fetch_unit: PC owner feeding a 2-entry fetch queue with redirect flush and fault halt
module fetch_unit #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int INST_NUM = 50
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] inst_adr,
  input  logic [N-1:0] inst_data,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_inst,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_pc_plus4,
  output logic         misalign_err,
  output logic         range_halt
);
  localparam logic [N-1:0] LIMIT = N'(INST_NUM * 4);
  logic [N-1:0] pc, pc_plus4;
  logic [N-1:0] q_inst [2];
  logic [N-1:0] q_pc [2];
  logic         rd_ptr, wr_ptr, pop, push;
  logic [1:0]   count;
  always_comb begin
    pc_plus4     = pc + N'(4);
    inst_adr     = pc;
    out_valid    = count != 2'd0;
    out_inst     = out_valid ? q_inst[rd_ptr] : '0;
    out_pc       = out_valid ? q_pc[rd_ptr] : '0;
    out_pc_plus4 = out_valid ? q_pc[rd_ptr] + N'(4) : '0;
    pop          = out_valid && out_ready;
    push         = !misalign_err && !range_halt && (count < 2'd2 || pop) && !redirect_valid;
  end
  // Queue storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= inst_data;
      q_pc[wr_ptr]   <= pc;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      misalign_err <= 1'b0;
      range_halt   <= RESET_PC >= LIMIT;
    end else if (redirect_valid) begin
      pc           <= redirect_pc;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      misalign_err <= redirect_pc[1:0] != 2'b00;
      range_halt   <= redirect_pc >= LIMIT;
    end else begin
      if (push) begin
        pc     <= pc_plus4;
        wr_ptr <= ~wr_ptr;
        if (pc_plus4 >= LIMIT) range_halt <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks for fetch_unit with word k = 0x1000_0000 + k
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_adr, inst_data, redirect_pc, out_inst, out_pc, out_pc_plus4;
  logic        redirect_valid, out_valid, out_ready, misalign_err, range_halt;
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(.N(32), .RESET_PC(32'h0), .INST_NUM(50)) dut (
    .clk(clk), .rst(rst), .inst_adr(inst_adr), .inst_data(inst_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .misalign_err(misalign_err), .range_halt(range_halt)
  );

  always #5 clk = ~clk;
  assign inst_data = 32'h1000_0000 + (inst_adr >> 2);

  task automatic restart(input logic [31:0] target);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, out_inst, out_pc, out_pc_plus4, misalign_err, range_halt, inst_adr} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b inst=%h pc=%h pc4=%h mis=%b halt=%b adr=%h, required all zero",
               out_valid, out_inst, out_pc, out_pc_plus4, misalign_err, range_halt, inst_adr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || inst_adr !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: v=%b adr=%h, required v=0 adr=0", out_valid, inst_adr);
    end
  endtask

  task automatic test_stream;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, out_inst, out_pc_plus4} !== {1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 32'(4 * i + 4)}) begin
        errors++;
        $display("FAIL stream[%0d]: v=%b pc=%h inst=%h pc4=%h, required v=1 pc=%h inst=%h pc4=%h",
                 i, out_valid, out_pc, out_inst, out_pc_plus4, 4 * i, 32'h1000_0000 + 32'(i), 4 * i + 4);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    restart(32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h1000_0000} || (i > 0 && inst_adr !== 32'h8)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b pc=%h inst=%h adr=%h, required v=1 pc=0 inst=10000000 adr=8",
                 i, out_valid, out_pc, out_inst, inst_adr);
      end
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i)}) begin
        errors++;
        $display("FAIL bp_drain[%0d]: v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 4 * i, 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_redirect_full;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || inst_adr !== 32'h40) begin
      errors++;
      $display("FAIL redir_flush: v=%b adr=%h, required v=0 adr=40", out_valid, inst_adr);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_inst, out_pc_plus4} !== {1'b1, 32'h40, 32'h1000_0010, 32'h44}) begin
      errors++;
      $display("FAIL redir_first: v=%b pc=%h inst=%h pc4=%h, required v=1 pc=40 inst=10000010 pc4=44",
               out_valid, out_pc, out_inst, out_pc_plus4);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h44, 32'h1000_0011}) begin
      errors++;
      $display("FAIL redir_second: v=%b pc=%h inst=%h, required v=1 pc=44 inst=10000011", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_misalign;
    restart(32'h22);
    checks++;
    if ({misalign_err, out_valid, inst_adr} !== {1'b1, 1'b0, 32'h22}) begin
      errors++;
      $display("FAIL mis_set: mis=%b v=%b adr=%h, required mis=1 v=0 adr=22", misalign_err, out_valid, inst_adr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({misalign_err, out_valid, inst_adr} !== {1'b1, 1'b0, 32'h22}) begin
      errors++;
      $display("FAIL mis_stall: mis=%b v=%b adr=%h, required mis=1 v=0 adr=22", misalign_err, out_valid, inst_adr);
    end
    restart(32'h10);
    checks++;
    if ({misalign_err, inst_adr} !== {1'b0, 32'h10}) begin
      errors++;
      $display("FAIL mis_clear: mis=%b adr=%h, required mis=0 adr=10", misalign_err, inst_adr);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h10, 32'h1000_0004}) begin
      errors++;
      $display("FAIL mis_resume: v=%b pc=%h inst=%h, required v=1 pc=10 inst=10000004", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_range_end;
    restart(32'hC0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_inst, range_halt} !== {1'b1, 32'hC0, 32'h1000_0030, 1'b0}) begin
      errors++;
      $display("FAIL range_c0: v=%b pc=%h inst=%h halt=%b, required v=1 pc=c0 inst=10000030 halt=0",
               out_valid, out_pc, out_inst, range_halt);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_inst, range_halt, inst_adr} !== {1'b1, 32'hC4, 32'h1000_0031, 1'b1, 32'hC8}) begin
      errors++;
      $display("FAIL range_c4: v=%b pc=%h inst=%h halt=%b adr=%h, required v=1 pc=c4 inst=10000031 halt=1 adr=c8",
               out_valid, out_pc, out_inst, range_halt, inst_adr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, range_halt, inst_adr} !== {1'b0, 1'b1, 32'hC8}) begin
        errors++;
        $display("FAIL range_halted[%0d]: v=%b halt=%b adr=%h pc=%h, required v=0 halt=1 adr=c8",
                 i, out_valid, range_halt, inst_adr, out_pc);
      end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    restart(32'h20);
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h20}) begin
      errors++;
      $display("FAIL ar_full: v=%b pc=%h, required v=1 pc=20", out_valid, out_pc);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_pc, inst_adr, range_halt} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL ar_immediate: v=%b pc=%h adr=%h halt=%b, required all zero", out_valid, out_pc, inst_adr, range_halt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      errors++;
      $display("FAIL ar_restart: v=%b pc=%h inst=%h, required v=1 pc=0 inst=10000000", out_valid, out_pc, out_inst);
    end
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_full;
    test_misalign;
    test_range_end;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned byte address to the memory.
- Captures the combinational read data into a 2-entry fetch queue and presents {instruction, pc, pc+4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects, flushes the queue on redirect, and flags misaligned or out-of-range fetch addresses.

Parameters:
- N, 32, data/address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INST_NUM, 50, number of instruction words in memory; valid fetch byte addresses are 0 .. INST_NUM*4-4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- inst_adr  output  N  byte address to instruction memory; equals pc at all times.
- inst_data  input  N  instruction word returned combinationally for inst_adr.
- redirect_valid  input  1  load redirect_pc as the new PC this cycle.
- redirect_pc  input  N  redirect target byte address.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  N  head instruction word.
- out_pc  output  N  head instruction byte address.
- out_pc_plus4  output  N  out_pc + 4, modulo 2^N.
- misalign_err  output  1  sticky; PC low two bits are nonzero.
- range_halt  output  1  pc >= INST_NUM*4; fetching is stopped.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC; queue count = 0.
  - out_valid = 0; out_inst, out_pc, out_pc_plus4 = 0.
  - misalign_err = 0; range_halt = (RESET_PC >= INST_NUM*4).
  - A reset mid-operation discards all queued entries immediately.
- Definitions:
  - fetch_ok = !misalign_err && !range_halt.
  - pop = out_valid && out_ready.
  - push = fetch_ok && (count < 2 || pop) && !redirect_valid.
- Push: writes {inst_data, pc} to the queue tail and sets pc <= pc + 4 on the same edge. Fetch latency is 1 cycle: a word fetched at edge k appears at the head after edge k if the queue was empty.
- Pop: removes the head. Simultaneous push and pop at count = 2 is legal; count stays 2.
- Redirect (highest priority, checked in this order):
  - When redirect_valid = 1 on an edge: queue flushed (count = 0), pc <= redirect_pc, no push, and any pop that cycle is ignored (the entry is discarded).
  - misalign_err <= (redirect_pc[1:0] != 0).
  - range_halt <= (redirect_pc >= INST_NUM*4).
- Without a redirect:
  - range_halt sets when pc + 4 >= INST_NUM*4 after a push.
  - misalign_err only changes on a redirect or reset.
- While misalign_err or range_halt is set:
  - pc holds and no pushes occur.
  - Queued entries still drain normally.
- Queue:
  - 2 entries, circular read/write pointers (1 bit each), count 0..2.
  - out_* reflect the head combinationally from the queue registers, not from inst_data.
- Output holding: when out_valid = 1 and out_ready = 0, out_inst, out_pc and out_pc_plus4 hold stable until popped or flushed.
- PC arithmetic: pc + 4 wraps modulo 2^N. Wrap-around past INST_NUM*4 is caught by range_halt before overflow.

Test Plan:
1. Reset with RESET_PC = 0, out_ready = 1, memory word k = 0x1000_0000+k → from cycle 1 each cycle out_valid = 1 with out_pc = 0, 4, 8…, out_inst = 0x1000_0000, 0x1000_0001…, out_pc_plus4 = out_pc + 4.
2. Backpressure: out_ready = 0 for 5 cycles → count reaches 2 with pc = 8 held; out_pc = 0 stays stable. Raising out_ready → entries at pc 0, 4, 8 delivered in order with no loss or duplication.
3. Redirect with a full queue: redirect_valid = 1, redirect_pc = 0x40, out_ready = 1 in the same cycle → both queued entries discarded and nothing popped. The next out_valid shows out_pc = 0x40 with inst = word 16.
4. Misaligned redirect: redirect_pc = 0x22 → misalign_err = 1, no further fetches, out_valid = 0 after the drain. A later redirect to 0x10 clears misalign_err and resumes fetching at 0x10.
5. Range end: redirect_pc = 0xC0 (word 48), INST_NUM = 50 → entries at 0xC0 and 0xC4 delivered, then range_halt = 1 with pc = 0xC8, and no entry at 0xC8 is ever produced.
6. Async reset asserted mid-cycle with count = 2 → out_valid = 0 immediately without waiting for a clock edge. After release, the first out_pc = RESET_PC.
